// File: rtl/fp16_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp16_arb_pkg : shared types for the FP16 multiplier arbiter                |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package fp16_arb_pkg;

  localparam int FP16_W   = 16;
  // Tag id is sized for up to 256 requesters; only the low bits are used.
  localparam int TAG_ID_W = 8;

  typedef logic [FP16_W-1:0] fp16_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin grant starting after last winner    |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   last,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_any
);

  int unsigned      scan;
  logic [IDX_W-1:0] pos;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    scan      = 0;
    pos       = '0;
    // Scan last+1 .. last+NUM_REQ modulo NUM_REQ; the first valid one wins.
    for (int k = 1; k <= NUM_REQ; k++) begin
      scan = (int'(last) + k) % NUM_REQ;
      pos  = IDX_W'(scan);
      if (!grant_any && req_valid[pos]) begin
        grant[pos] = 1'b1;
        grant_idx  = pos;
        grant_any  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fp16_mult_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fp16_mult_arbiter : round-robin sharing of one FP16 multiplier, with tag   |
// | pipeline routing products back. Optional busy_cnt via FP16_ARB_STATS_EN.   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module fp16_mult_arbiter
  import fp16_arb_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int MULT_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [16*NUM_REQ-1:0]  req_a,
  input  logic [16*NUM_REQ-1:0]  req_b,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [15:0]            rsp_x,
  output logic [15:0]            mult_a,
  output logic [15:0]            mult_b,
  input  logic [15:0]            mult_x
`ifdef FP16_ARB_STATS_EN
  , output logic [31:0]          busy_cnt
`endif
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_any;
  logic               xfer;
  logic [IDX_W-1:0]   last;
  fp16_t              sel_a;
  fp16_t              sel_b;
  tag_t               tags [MULT_LATENCY];

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_arbiter (
    .req_valid (req_valid),
    .last      (last),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_any (grant_any)
  );

  assign req_ready = rst ? '0 : grant;
  assign xfer      = grant_any && !rst;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*FP16_W +: FP16_W];
        sel_b = req_b[i*FP16_W +: FP16_W];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mult_a <= '0;
      mult_b <= '0;
      last   <= IDX_W'(NUM_REQ - 1);
      for (int s = 0; s < MULT_LATENCY; s++) begin
        tags[s] <= '0;
      end
    end else begin
      if (xfer) begin
        mult_a <= sel_a;
        mult_b <= sel_b;
        last   <= grant_idx;
      end
      // The tag pipeline never stalls: it mirrors the multiplier's fixed latency.
      tags[0] <= '{valid: xfer, id: TAG_ID_W'(grant_idx)};
      for (int s = 1; s < MULT_LATENCY; s++) begin
        tags[s] <= tags[s-1];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (tags[MULT_LATENCY-1].valid) begin
      rsp_valid[tags[MULT_LATENCY-1].id[IDX_W-1:0]] = 1'b1;
    end
  end

  assign rsp_x = mult_x;

`ifdef FP16_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt <= '0;
    end else if (xfer) begin
      busy_cnt <= busy_cnt + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fp16_mult_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fp16_mult_arbiter : directed table-driven bench, 4 requesters, L=2,     |
// | behavioural FP16 multiplier (normals only). Rev 1.0                        |
// +----------------------------------------------------------------------------+
module tb_fp16_mult_arbiter;

  localparam int N = 4;
  localparam int L = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [16*N-1:0] req_a;
  logic [16*N-1:0] req_b;
  logic [N-1:0]  rsp_valid;
  logic [15:0]   rsp_x;
  logic [15:0]   mult_a;
  logic [15:0]   mult_b;
  logic [15:0]   mult_x;
  logic [15:0]   mult_pipe;
`ifdef FP16_ARB_STATS_EN
  logic [31:0]   busy_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fp16_mult_arbiter #(.NUM_REQ(N), .MULT_LATENCY(L)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_x     (rsp_x),
    .mult_a    (mult_a),
    .mult_b    (mult_b),
    .mult_x    (mult_x)
`ifdef FP16_ARB_STATS_EN
    , .busy_cnt (busy_cnt)
`endif
  );

  // Round-to-nearest-even FP16 multiply for normal operands.
  function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
    logic [10:0] ma, mb, m;
    logic [21:0] p;
    logic [11:0] mr;
    logic        g, st;
    int          e;
    ma = {1'b1, a[9:0]};
    mb = {1'b1, b[9:0]};
    p  = 22'(ma) * 22'(mb);
    e  = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (p[21]) begin
      e++; m = p[21:11]; g = p[10]; st = |p[9:0];
    end else begin
      m = p[20:10]; g = p[9]; st = |p[8:0];
    end
    mr = {1'b0, m} + 12'((g && (st || m[0])) ? 1 : 0);
    if (mr[11]) begin
      e++; mr = mr >> 1;
    end
    return {a[15] ^ b[15], 5'(e), mr[9:0]};
  endfunction

  // Multiplier model: L-1 register stages after the DUT's operand registers.
  always_ff @(posedge clk) mult_pipe <= fp16_mul(mult_a, mult_b);
  assign mult_x = mult_pipe;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [N-1:0]   valid;
    logic [16*N-1:0] a;
    logic [16*N-1:0] b;
    logic [N-1:0]   exp_ready;
    logic [N-1:0]   exp_rsp;
    logic [15:0]    exp_x;
  } vec_t;

  vec_t tbl [18];

  localparam logic [63:0] A_D = {16'h3F00, 16'h3E00, 16'h3D00, 16'h3C00};
  localparam logic [63:0] B_D = {16'h4000, 16'h4000, 16'h4000, 16'h4000};
  localparam logic [63:0] A_S = {16'h3F00, 16'h3E00, 16'h4766, 16'h3C00};
  localparam logic [63:0] B_S = {16'h4000, 16'h4000, 16'h4826, 16'h4000};

  initial begin
    tbl[0]  = '{4'b1111, A_D, B_D, 4'b0001, 4'b0000, 16'h0000};
    tbl[1]  = '{4'b1111, A_D, B_D, 4'b0010, 4'b0000, 16'h0000};
    tbl[2]  = '{4'b1111, A_D, B_D, 4'b0100, 4'b0001, 16'h4000};
    tbl[3]  = '{4'b1111, A_D, B_D, 4'b1000, 4'b0010, 16'h4100};
    tbl[4]  = '{4'b1111, A_D, B_D, 4'b0001, 4'b0100, 16'h4200};
    tbl[5]  = '{4'b1111, A_D, B_D, 4'b0010, 4'b1000, 16'h4300};
    tbl[6]  = '{4'b1111, A_D, B_D, 4'b0100, 4'b0001, 16'h4000};
    tbl[7]  = '{4'b1111, A_D, B_D, 4'b1000, 4'b0010, 16'h4100};
    tbl[8]  = '{4'b0000, A_D, B_D, 4'b0000, 4'b0100, 16'h4200};
    tbl[9]  = '{4'b0000, A_D, B_D, 4'b0000, 4'b1000, 16'h4300};
    tbl[10] = '{4'b0010, A_S, B_S, 4'b0010, 4'b0000, 16'h0000};
    tbl[11] = '{4'b0000, A_D, B_D, 4'b0000, 4'b0000, 16'h0000};
    tbl[12] = '{4'b0000, A_D, B_D, 4'b0000, 4'b0010, 16'h53AC};
    tbl[13] = '{4'b0100, A_D, B_D, 4'b0100, 4'b0000, 16'h0000};
    tbl[14] = '{4'b1100, A_D, B_D, 4'b1000, 4'b0000, 16'h0000};
    tbl[15] = '{4'b1100, A_D, B_D, 4'b0100, 4'b0100, 16'h4200};
    tbl[16] = '{4'b0000, A_D, B_D, 4'b0000, 4'b1000, 16'h4300};
    tbl[17] = '{4'b0000, A_D, B_D, 4'b0000, 4'b0100, 16'h4200};

    // Reset state with all requesters asking
    rst = 1'b1; req_valid = 4'b1111; req_a = A_D; req_b = B_D;
    #2;
    chk("reset_ready", 32'(req_ready), 32'h0);
    chk("reset_rsp",   32'(rsp_valid), 32'h0);
    chk("reset_mult_a", 32'(mult_a), 32'h0);
    chk("reset_mult_b", 32'(mult_b), 32'h0);
    cyc(); cyc();
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      req_valid = tbl[i].valid; req_a = tbl[i].a; req_b = tbl[i].b;
      #1;
      chk($sformatf("row%0d_ready", i), 32'(req_ready), 32'(tbl[i].exp_ready));
      chk($sformatf("row%0d_rsp", i),   32'(rsp_valid), 32'(tbl[i].exp_rsp));
      if (tbl[i].exp_rsp != 4'b0000)
        chk($sformatf("row%0d_x", i), 32'(rsp_x), 32'(tbl[i].exp_x));
      cyc();
    end

    // Reset one cycle after a transfer: the in-flight tag must vanish
    req_valid = 4'b0000; req_a = A_D; req_b = B_D;
    rst = 1'b1; cyc(); rst = 1'b0;
    req_valid = 4'b0010; #1;
    chk("midrst_grant", 32'(req_ready), 32'b0010);
    cyc();
    req_valid = 4'b0000; rst = 1'b1; #1;
    chk("midrst_mult_a", 32'(mult_a), 32'h0);
    chk("midrst_rsp", 32'(rsp_valid), 32'h0);
    cyc(); cyc();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk($sformatf("midrst_quiet%0d", i), 32'(rsp_valid), 32'h0);
      cyc();
    end
    req_valid = 4'b1111; #1;
    chk("post_rst_grant", 32'(req_ready), 32'b0001);
    cyc();

    // Idle cycles interleaved with transfers
    req_valid = 4'b0000; #1;
    chk("idle1_mult_a", 32'(mult_a), 32'h3C00);
    chk("idle1_rsp", 32'(rsp_valid), 32'h0);
    cyc();
    req_valid = 4'b0100; #1;
    chk("xfer2_ready", 32'(req_ready), 32'b0100);
    chk("xfer2_rsp", 32'(rsp_valid), 32'b0001);
    chk("xfer2_x", 32'(rsp_x), 32'h4000);
    cyc();
    req_valid = 4'b0000; #1;
    chk("idle2_rsp", 32'(rsp_valid), 32'h0);
    chk("idle2_mult_a", 32'(mult_a), 32'h3E00);
    cyc(); #1;
    chk("idle3_rsp", 32'(rsp_valid), 32'b0100);
    chk("idle3_x", 32'(rsp_x), 32'h4200);
    cyc(); #1;
    chk("idle4_rsp", 32'(rsp_valid), 32'h0);
    chk("idle4_mult_a", 32'(mult_a), 32'h3E00);
    chk("idle4_mult_b", 32'(mult_b), 32'h4000);

`ifdef FP16_ARB_STATS_EN
    rst = 1'b1; cyc(); rst = 1'b0;
    chk("stats_reset", busy_cnt, 32'd0);
    req_valid = 4'b1111;
    for (int i = 0; i < 10; i++) cyc();
    req_valid = 4'b0000; cyc(); cyc();
    chk("stats_count", busy_cnt, 32'd10);
    rst = 1'b1; #1;
    chk("stats_clear", busy_cnt, 32'd0);
    cyc(); rst = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
